wave_display_multi: RTL and testbench

Parametrised successor to the single-channel wave display. It captures NUM_CH interleaved audio channels into a double-buffered sample store. An optional rising-zero-crossing trigger gives a stable waveform between frames. Each pixel (x,y) from the DVI controller is rendered as a per-channel coloured trace with vertical line fill between adjacent samples. It sits between the codec/sample path and dvi_controller_top, and drives r/g/b.

---
 rtl/wave_display_multi_pkg.sv | 29 ++
 rtl/wave_display_multi_sample_bank.sv | 31 +++
 rtl/wave_display_multi.sv | 164 ++++++++++++++++
 tb/tb_wave_display_multi.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_display_multi_pkg.sv
// Shared types and constants for the multi-channel wave display: capture
// states, per-channel trace colours and the window geometry.
package wave_display_multi_pkg;

  typedef enum logic [1:0] {
    CAP_ARMED   = 2'd0,
    CAP_CAPTURE = 2'd1,
    CAP_FULL    = 2'd2
  } cap_state_t;

  localparam int WIN_ROWS = 256;

  localparam logic [23:0] COLOUR_CH0   = 24'h00FF00;
  localparam logic [23:0] COLOUR_CH1   = 24'hFFFF00;
  localparam logic [23:0] COLOUR_CH2   = 24'h00FFFF;
  localparam logic [23:0] COLOUR_CH3   = 24'hFF00FF;
  localparam logic [23:0] COLOUR_BG    = 24'h202020;
  localparam logic [23:0] COLOUR_BLACK = 24'h000000;

  function automatic logic [23:0] ch_colour(input int ch);
    case (ch)
      0:       return COLOUR_CH0;
      1:       return COLOUR_CH1;
      2:       return COLOUR_CH2;
      default: return COLOUR_CH3;
    endcase
  endfunction

endpackage

// File: rtl/wave_display_multi_sample_bank.sv
// Double-buffered sample store: one bank is written by capture while the
// other is read (current and previous address) for display.
module wave_sample_bank #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_bank,
  input  logic [AW-1:0]    raddr_cur,
  input  logic [AW-1:0]    raddr_prev,
  output logic [WIDTH-1:0] rdata_cur,
  output logic [WIDTH-1:0] rdata_prev
);

  logic [WIDTH-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata_cur  <= mem[rd_bank][raddr_cur];
    rdata_prev <= mem[rd_bank][raddr_prev];
  end

endmodule

// File: rtl/wave_display_multi.sv
// Multi-channel wave display: triggered double-buffered capture plus a
// two-cycle render pipeline drawing line-filled coloured traces.
module wave_display_multi
  import wave_display_multi_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SAMPLE_W    = 16,
  parameter int NUM_SAMPLES = 256,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int X_OFF       = 16,
  parameter int Y_OFF       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_sample,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample,
  input  logic                       trig_en,
  input  logic                       freeze,
  input  logic [X_W-1:0]             x,
  input  logic [Y_W-1:0]             y,
  input  logic                       valid,
  input  logic                       vsync,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b,
  output logic                       frame_swapped,
  output logic [1:0]                 cap_state
);

  localparam int AW    = $clog2(NUM_SAMPLES);
  localparam int BUS_W = NUM_CH * SAMPLE_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SAMPLES - 1);
  localparam logic [X_W:0]  X_LO = (X_W+1)'(X_OFF);
  localparam logic [X_W:0]  X_HI = (X_W+1)'(X_OFF + 2*NUM_SAMPLES);
  localparam logic [Y_W:0]  Y_LO = (Y_W+1)'(Y_OFF);
  localparam logic [Y_W:0]  Y_HI = (Y_W+1)'(Y_OFF + WIN_ROWS);

  // Screen row of a sample: top 8 bits as offset binary, full scale at the top.
  function automatic logic [Y_W:0] sample_row(input logic signed [SAMPLE_W-1:0] s);
    logic [7:0] level;
    level = {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: 7]};
    return (Y_W+1)'(Y_OFF + WIN_ROWS - 1) - {{(Y_W-7){1'b0}}, level};
  endfunction

  cap_state_t    state, state_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic          disp_bank, vsync_q, prev_msb, have_frame;
  logic          vsync_fall, swap, trig_hit, we;

  assign vsync_fall = vsync_q & ~vsync;
  assign swap       = vsync_fall && (state == CAP_FULL) && !freeze;
  assign trig_hit   = prev_msb && !sample[SAMPLE_W-1];
  assign cap_state  = state;

  // A swap takes priority over any sample arriving in the same cycle.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    we         = 1'b0;
    if (swap) begin
      state_nxt  = trig_en ? CAP_ARMED : CAP_CAPTURE;
      wr_ptr_nxt = '0;
    end else if (new_sample) begin
      case (state)
        CAP_ARMED: if (trig_hit) begin
          we         = 1'b1;
          wr_ptr_nxt = wr_ptr + AW'(1);
          state_nxt  = (wr_ptr == LAST_ADDR) ? CAP_FULL : CAP_CAPTURE;
        end
        CAP_CAPTURE: begin
          we         = 1'b1;
          wr_ptr_nxt = wr_ptr + AW'(1);
          if (wr_ptr == LAST_ADDR) state_nxt = CAP_FULL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= trig_en ? CAP_ARMED : CAP_CAPTURE;
      wr_ptr        <= '0;
      disp_bank     <= 1'b0;
      vsync_q       <= 1'b1;
      prev_msb      <= 1'b0;
      have_frame    <= 1'b0;
      frame_swapped <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_ptr_nxt;
      vsync_q       <= vsync;
      frame_swapped <= swap;
      if (new_sample) prev_msb <= sample[SAMPLE_W-1];
      if (swap) begin
        disp_bank  <= ~disp_bank;
        have_frame <= 1'b1;
      end
    end
  end

  // Stage 1: window test and bank read of current/previous sample
  logic           in_win;
  logic [X_W-1:0] x_rel;
  logic [AW-1:0]  rd_addr, rd_addr_prev;
  logic [BUS_W-1:0] rd_cur_p1, rd_prev_p1;
  logic           vld_p1;
  logic [Y_W-1:0] y_p1;

  assign in_win = valid && ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI)
                        && ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
  assign x_rel        = x - X_W'(X_OFF);
  assign rd_addr      = AW'(x_rel >> 1);
  assign rd_addr_prev = (rd_addr == '0) ? '0 : rd_addr - AW'(1);

  wave_sample_bank #(
    .DEPTH (NUM_SAMPLES),
    .WIDTH (BUS_W),
    .AW    (AW)
  ) u_bank (
    .clk        (clk),
    .we         (we),
    .wr_bank    (~disp_bank),
    .waddr      (wr_ptr),
    .wdata      (sample),
    .rd_bank    (disp_bank),
    .raddr_cur  (rd_addr),
    .raddr_prev (rd_addr_prev),
    .rdata_cur  (rd_cur_p1),
    .rdata_prev (rd_prev_p1)
  );

  always_ff @(posedge clk) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= in_win;
  end

  always_ff @(posedge clk) begin
    y_p1 <= y;
  end

  // Stage 2: per-channel span hit test, lowest channel index wins
  logic [23:0] rgb_nxt;

  always_comb begin
    logic [Y_W:0] row_c, row_p, lo, hi;
    rgb_nxt = COLOUR_BG;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      row_c = sample_row(rd_cur_p1[c*SAMPLE_W +: SAMPLE_W]);
      row_p = sample_row(rd_prev_p1[c*SAMPLE_W +: SAMPLE_W]);
      lo    = (row_c < row_p) ? row_c : row_p;
      hi    = (row_c < row_p) ? row_p : row_c;
      if (({1'b0, y_p1} >= lo) && ({1'b0, y_p1} <= hi)) rgb_nxt = ch_colour(c);
    end
    if (!vld_p1 || !have_frame) rgb_nxt = COLOUR_BLACK;
  end

  always_ff @(posedge clk) begin
    if (!reset) {r, g, b} <= COLOUR_BLACK;
    else        {r, g, b} <= rgb_nxt;
  end

endmodule

// File: tb/tb_wave_display_multi.sv
// Directed and randomized bench for wave_display_multi, checked against a
// frame-level model of capture, swapping and pixel colouring.
module tb_wave_display_multi;

  localparam int NCH   = 2;
  localparam int SW    = 16;
  localparam int NS    = 256;
  localparam int XW    = 11;
  localparam int YW    = 10;
  localparam int XOFF  = 16;
  localparam int YOFF  = 32;
  localparam int BUS_W = NCH * SW;

  typedef logic [BUS_W-1:0] bus_t;

  logic             clk = 1'b0;
  logic             reset, new_sample, trig_en, freeze, valid, vsync;
  logic [BUS_W-1:0] sample;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [7:0]       r, g, b;
  logic             frame_swapped;
  logic [1:0]       cap_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wave_display_multi #(
    .NUM_CH(NCH), .SAMPLE_W(SW), .NUM_SAMPLES(NS),
    .X_W(XW), .Y_W(YW), .X_OFF(XOFF), .Y_OFF(YOFF)
  ) dut (
    .clk(clk), .reset(reset), .new_sample(new_sample), .sample(sample),
    .trig_en(trig_en), .freeze(freeze), .x(x), .y(y), .valid(valid),
    .vsync(vsync), .r(r), .g(g), .b(b),
    .frame_swapped(frame_swapped), .cap_state(cap_state)
  );

  // Model: frames as arrays of bus words, capture as a growing queue.
  bus_t        m_fill[$];
  bus_t        m_disp[NS];
  bit          m_armed, m_prev_neg, m_have;
  logic [23:0] cols[4] = '{24'h00FF00, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};

  function automatic int exp_state();
    if (m_armed) return 0;
    if (m_fill.size() == NS) return 2;
    return 1;
  endfunction

  function automatic void model_reset(bit te);
    m_fill.delete();
    m_armed = te;
    m_prev_neg = 0;
    m_have = 0;
  endfunction

  function automatic void model_strobe(bus_t s);
    bit neg;
    neg = s[SW-1];
    if (m_armed) begin
      if (m_prev_neg && !neg) begin
        m_armed = 0;
        m_fill.push_back(s);
      end
    end else if (m_fill.size() < NS) begin
      m_fill.push_back(s);
    end
    m_prev_neg = neg;
  endfunction

  function automatic bit model_vsync(bit frz, bit te);
    if (m_fill.size() != NS || frz) return 0;
    for (int i = 0; i < NS; i++) m_disp[i] = m_fill[i];
    m_fill.delete();
    m_armed = te;
    m_have = 1;
    return 1;
  endfunction

  function automatic int level_row(bus_t w, int ch);
    logic signed [SW-1:0] s;
    int v;
    s = w[ch*SW +: SW];
    v = int'(s);
    return YOFF + 255 - ((v + 32768) / 256);
  endfunction

  function automatic logic [23:0] model_rgb(int px, int py, bit pv);
    int a, rc, rp, lo, hi;
    if (!pv || px < XOFF || px >= XOFF + 2*NS || py < YOFF || py >= YOFF + 256) return 24'h0;
    if (!m_have) return 24'h0;
    a = (px - XOFF) / 2;
    for (int c = 0; c < NCH; c++) begin
      rc = level_row(m_disp[a], c);
      rp = (a == 0) ? rc : level_row(m_disp[a-1], c);
      lo = (rc < rp) ? rc : rp;
      hi = (rc < rp) ? rp : rc;
      if (py >= lo && py <= hi) return cols[c];
    end
    return 24'h202020;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input bus_t s);
    new_sample = 1'b1;
    sample = s;
    model_strobe(s);
    tick();
    new_sample = 1'b0;
  endtask

  task automatic vedge(input string tag, input bit with_strobe, input bus_t s);
    bit sw;
    vsync = 1'b0;
    if (with_strobe) begin
      new_sample = 1'b1;
      sample = s;
    end
    sw = model_vsync(freeze, trig_en);
    if (with_strobe) begin
      if (sw) m_prev_neg = s[SW-1];
      else model_strobe(s);
    end
    tick();
    new_sample = 1'b0;
    chk({tag, "_swap"}, 32'(frame_swapped), 32'(sw));
    chk({tag, "_state"}, 32'(cap_state), 32'(exp_state()));
    tick();
    chk({tag, "_pulse_end"}, 32'(frame_swapped), 32'd0);
    vsync = 1'b1;
    tick();
  endtask

  task automatic pix(input string tag, input int px, input int py, input bit pv,
                     input logic [23:0] exp);
    x = XW'(px);
    y = YW'(py);
    valid = pv;
    tick();
    tick();
    chk(tag, 32'({r, g, b}), 32'(exp));
    valid = 1'b0;
  endtask

  task automatic rand_pixels(input string tag, input int n);
    int px, py;
    bit pv;
    for (int i = 0; i < n; i++) begin
      px = XOFF - 4 + int'($urandom_range(0, 2*NS + 8));
      py = YOFF - 4 + int'($urandom_range(0, 263));
      pv = ($urandom_range(0, 7) != 0);
      pix(tag, px, py, pv, model_rgb(px, py, pv));
    end
  endtask

  initial begin
    bus_t s;
    reset = 1'b0; new_sample = 1'b0; sample = '0; trig_en = 1'b0;
    freeze = 1'b0; valid = 1'b0; vsync = 1'b1; x = '0; y = '0;
    model_reset(1'b0);
    tick();
    tick();
    chk("reset_rgb", 32'({r, g, b}), 32'h0);
    chk("reset_state", 32'(cap_state), 32'd1);
    chk("reset_swap", 32'(frame_swapped), 32'd0);
    reset = 1'b1;
    tick();
    pix("black_before_swap", XOFF + 10, YOFF + 127, 1'b1, 24'h0);

    // Free-run fill with constant levels.
    for (int i = 0; i < NS; i++) strobe({16'h7F00, 16'h0000});
    chk("full_state", 32'(cap_state), 32'd2);
    vedge("first_swap", 1'b0, '0);
    pix("ch0_trace", XOFF + 10, YOFF + 127, 1'b1, 24'h00FF00);
    pix("ch1_trace", XOFF + 10, YOFF + 0, 1'b1, 24'hFFFF00);
    pix("bg", XOFF + 10, YOFF + 200, 1'b1, 24'h202020);
    pix("out_x0", 0, YOFF + 127, 1'b1, 24'h0);
    pix("valid0", XOFF + 10, YOFF + 127, 1'b0, 24'h0);
    pix("right_edge_out", XOFF + 2*NS, YOFF + 127, 1'b1, 24'h0);

    // Random frame; swap coincides with a strobe, which is dropped.
    for (int i = 0; i < NS; i++) strobe(bus_t'($urandom));
    vedge("swap_with_strobe", 1'b1, bus_t'($urandom));
    rand_pixels("rand_frame", 60);

    // Freeze holds the display across edges.
    for (int i = 0; i < NS; i++) strobe(bus_t'($urandom));
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) vedge("frozen", 1'b0, '0);
    rand_pixels("frozen_display", 20);
    freeze = 1'b0;
    vedge("unfreeze", 1'b0, '0);
    rand_pixels("after_unfreeze", 20);

    // Partial fill: edge must not swap; then complete with a full-scale step.
    for (int i = 0; i < 100; i++) strobe(bus_t'($urandom));
    vedge("partial", 1'b0, '0);
    rand_pixels("partial_hold", 10);
    for (int i = 100; i < NS; i++) begin
      s = bus_t'($urandom);
      if (i == 120) s[15:0] = 16'h7F00;
      if (i == 121) s[15:0] = 16'h8000;
      strobe(s);
    end
    vedge("fill_swap", 1'b0, '0);
    for (int row = 0; row < 256; row++)
      pix("line_fill", XOFF + 242, YOFF + row, 1'b1, 24'h00FF00);

    // Reset mid-frame blanks the output on the next cycle.
    x = XW'(XOFF + 242); y = YW'(YOFF + 5); valid = 1'b1;
    tick(); tick();
    chk("pre_reset_rgb", 32'({r, g, b}), 32'h00FF00);
    trig_en = 1'b1;
    reset = 1'b0;
    model_reset(1'b1);
    tick();
    chk("midreset_rgb", 32'({r, g, b}), 32'h0);
    chk("midreset_state", 32'(cap_state), 32'd0);
    reset = 1'b1;
    valid = 1'b0;
    tick();

    // Trigger on ch0 rising zero crossing.
    strobe({16'h8000, 16'hA439});
    chk("trig_a439", 32'(cap_state), 32'(exp_state()));
    strobe({16'h8000, 16'h8000});
    chk("trig_8000", 32'(cap_state), 32'd0);
    strobe({16'h8000, 16'h1234});
    chk("trig_1234", 32'(cap_state), 32'd1);
    for (int i = 1; i < NS; i++) strobe(bus_t'($urandom));
    vedge("trig_swap", 1'b0, '0);
    pix("addr0_1234", XOFF, YOFF + 109, 1'b1, 24'h00FF00);
    pix("addr0_gap", XOFF + 1, YOFF + 108, 1'b1, 24'h202020);
    rand_pixels("trig_frame", 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
